// File: rtl/control_sequencer_if.sv
// Bus bundle between control_sequencer (master) and the datapath side (slave).
interface control_sequencer_if;
  logic        start;
  logic        mem_rdy;
  logic [31:0] ir;
  logic [31:0] enable;
  logic [31:0] busSelect;
  logic [4:0]  Control_Signals;
  logic        MD_Read;
  logic        ReadRAM;
  logic        WriteRAM;
  logic        Gra;
  logic        Grb;
  logic        Grc;
  logic        Rin;
  logic        Rout;
  logic        BAout;
  logic        run;
  logic        illegal;
  logic [3:0]  step;

  modport master (
    input  start, mem_rdy, ir,
    output enable, busSelect, Control_Signals,
    output MD_Read, ReadRAM, WriteRAM,
    output Gra, Grb, Grc, Rin, Rout, BAout,
    output run, illegal, step
  );

  modport slave (
    output start, mem_rdy, ir,
    input  enable, busSelect, Control_Signals,
    input  MD_Read, ReadRAM, WriteRAM,
    input  Gra, Grb, Grc, Rin, Rout, BAout,
    input  run, illegal, step
  );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired T-state control unit for the single-bus datapath.
// Optional macro CU_MEM_WAIT_EN: stretch memory T-states until mem_rdy.
module control_sequencer (
  input  logic                 clk,
  input  logic                 clr,
  control_sequencer_if.master  bus
);

  localparam logic [4:0] INC_PC_OP = 5'd14;
  localparam logic [4:0] ADD_OP    = 5'd1;
  localparam logic [4:0] SUB_OP    = 5'd2;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3,
    S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic       r_illegal;
  logic [4:0] w_op;
  logic       w_undef;
  logic       w_mem_ok;

  assign w_op = bus.ir[31:27];

`ifdef CU_MEM_WAIT_EN
  logic w_unused;
  assign w_mem_ok = bus.mem_rdy;
  assign w_unused = ^bus.ir[26:0];
`else
  logic w_unused;
  assign w_mem_ok = 1'b1;
  assign w_unused = ^{bus.ir[26:0], bus.mem_rdy};
`endif

  always_comb begin
    w_undef = 1'b1;
    case (w_op)
      OP_LD, OP_LDI, OP_ST, OP_ADD,
      OP_SUB, OP_NOP, OP_HALT: w_undef = 1'b0;
      default:                 w_undef = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state   <= S_IDLE;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_T3 && w_undef)
        r_illegal <= 1'b1;
    end
  end

  // illegal shows in T3 itself, then the sticky flag carries it
  assign bus.illegal = r_illegal | ((r_state == S_T3) & w_undef);

  always_comb begin
    w_next              = r_state;
    bus.enable          = '0;
    bus.busSelect       = '0;
    bus.Control_Signals = '0;
    bus.MD_Read         = 1'b0;
    bus.ReadRAM         = 1'b0;
    bus.WriteRAM        = 1'b0;
    bus.Gra             = 1'b0;
    bus.Grb             = 1'b0;
    bus.Grc             = 1'b0;
    bus.Rin             = 1'b0;
    bus.Rout            = 1'b0;
    bus.BAout           = 1'b0;
    bus.run             = 1'b0;
    bus.step            = 4'hF;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start)
          w_next = S_T0;
      end
      S_T0: begin
        bus.run             = 1'b1;
        bus.step            = 4'd0;
        bus.busSelect[20]   = 1'b1;
        bus.enable[25]      = 1'b1;
        bus.enable[18]      = 1'b1;
        bus.Control_Signals = INC_PC_OP;
        w_next              = S_T1;
      end
      S_T1: begin
        bus.run           = 1'b1;
        bus.step          = 4'd1;
        bus.busSelect[19] = 1'b1;
        bus.enable[20]    = 1'b1;
        bus.enable[21]    = 1'b1;
        bus.MD_Read       = 1'b1;
        bus.ReadRAM       = 1'b1;
        w_next            = w_mem_ok ? S_T2 : S_T1;
      end
      S_T2: begin
        bus.run           = 1'b1;
        bus.step          = 4'd2;
        bus.busSelect[21] = 1'b1;
        bus.enable[24]    = 1'b1;
        w_next            = S_T3;
      end
      S_T3: begin
        bus.run  = 1'b1;
        bus.step = 4'd3;
        w_next   = S_T0;
        case (w_op)
          OP_LD, OP_LDI, OP_ST: begin
            bus.Grb        = 1'b1;
            bus.BAout      = 1'b1;
            bus.enable[19] = 1'b1;
            w_next         = S_T4;
          end
          OP_ADD, OP_SUB: begin
            bus.Grb        = 1'b1;
            bus.Rout       = 1'b1;
            bus.enable[19] = 1'b1;
            w_next         = S_T4;
          end
          OP_HALT: w_next = S_HALT;
          default: w_next = S_T0;
        endcase
      end
      S_T4: begin
        bus.run        = 1'b1;
        bus.step       = 4'd4;
        bus.enable[18] = 1'b1;
        w_next         = S_T5;
        if (w_op == OP_ADD || w_op == OP_SUB) begin
          bus.Grc             = 1'b1;
          bus.Rout            = 1'b1;
          bus.Control_Signals =
            (w_op == OP_SUB) ? SUB_OP : ADD_OP;
        end else begin
          bus.busSelect[23]   = 1'b1;
          bus.Control_Signals = ADD_OP;
        end
      end
      S_T5: begin
        bus.run           = 1'b1;
        bus.step          = 4'd5;
        bus.busSelect[19] = 1'b1;
        if (w_op == OP_LD || w_op == OP_ST) begin
          bus.enable[25] = 1'b1;
          w_next         = S_T6;
        end else begin
          bus.Gra = 1'b1;
          bus.Rin = 1'b1;
          w_next  = S_T0;
        end
      end
      S_T6: begin
        bus.run        = 1'b1;
        bus.step       = 4'd6;
        bus.enable[21] = 1'b1;
        if (w_op == OP_ST) begin
          bus.Gra  = 1'b1;
          bus.Rout = 1'b1;
          w_next   = S_T7;
        end else begin
          bus.MD_Read = 1'b1;
          bus.ReadRAM = 1'b1;
          w_next      = w_mem_ok ? S_T7 : S_T6;
        end
      end
      S_T7: begin
        bus.run  = 1'b1;
        bus.step = 4'd7;
        if (w_op == OP_ST) begin
          bus.WriteRAM = 1'b1;
          w_next       = w_mem_ok ? S_T0 : S_T7;
        end else begin
          bus.busSelect[21] = 1'b1;
          bus.Gra           = 1'b1;
          bus.Rin           = 1'b1;
          w_next            = S_T0;
        end
      end
      S_HALT: w_next = S_HALT;
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed table, corner
// sequences and a randomized program against an instruction-level model.
module tb_control_sequencer;

  typedef struct packed {
    logic [31:0] en;
    logic [31:0] bs;
    logic [4:0]  cs;
    logic        md, rr, wr, gra, grb, grc, rin, rout, ba;
    logic        run, ill;
    logic [3:0]  step;
  } outs_t;

  typedef struct {
    string       name;
    logic [31:0] ir;
    int          t;
    logic [31:0] en;
    logic [31:0] bs;
    logic [4:0]  cs;
    logic [8:0]  ctl;
  } vec_t;

  localparam logic [8:0] C_MD   = 9'b100000000;
  localparam logic [8:0] C_RR   = 9'b010000000;
  localparam logic [8:0] C_WR   = 9'b001000000;
  localparam logic [8:0] C_GRA  = 9'b000100000;
  localparam logic [8:0] C_GRB  = 9'b000010000;
  localparam logic [8:0] C_GRC  = 9'b000001000;
  localparam logic [8:0] C_RIN  = 9'b000000100;
  localparam logic [8:0] C_ROUT = 9'b000000010;
  localparam logic [8:0] C_BA   = 9'b000000001;

  localparam logic [31:0] IR_LD   = 32'h0080_0000;
  localparam logic [31:0] IR_LDI  = 32'h0880_0005;
  localparam logic [31:0] IR_ST   = 32'h1000_0000;
  localparam logic [31:0] IR_ADD  = 32'h1800_0000;
  localparam logic [31:0] IR_SUB  = 32'h2000_0000;
  localparam logic [31:0] IR_NOP  = 32'hD000_0000;
  localparam logic [31:0] IR_HALT = 32'hD800_0000;
  localparam logic [31:0] IR_BAD  = 32'hF800_0000;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  control_sequencer_if bus ();
  control_sequencer dut (.clk(clk), .clr(clr), .bus(bus));

  int checks = 0;
  int failures = 0;

  function automatic outs_t sample();
    outs_t o;
    o.en = bus.enable;
    o.bs = bus.busSelect;
    o.cs = bus.Control_Signals;
    o.md = bus.MD_Read;
    o.rr = bus.ReadRAM;
    o.wr = bus.WriteRAM;
    o.gra = bus.Gra;
    o.grb = bus.Grb;
    o.grc = bus.Grc;
    o.rin = bus.Rin;
    o.rout = bus.Rout;
    o.ba = bus.BAout;
    o.run = bus.run;
    o.ill = bus.illegal;
    o.step = bus.step;
    return o;
  endfunction

  task automatic check(input string name, input outs_t got,
                       input outs_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic check_val(input string name, input int got,
                           input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  function automatic outs_t idle_o(input logic ill);
    outs_t o;
    o = '0;
    o.step = 4'hF;
    o.ill = ill;
    return o;
  endfunction

  function automatic logic is_undef(input logic [4:0] op);
    return !(op inside {5'd0, 5'd1, 5'd2, 5'd3, 5'd4,
                        5'b11010, 5'b11011});
  endfunction

  function automatic int instr_len(input logic [4:0] op);
    if (op == 5'd0 || op == 5'd2) return 8;
    if (op == 5'd1 || op == 5'd3 || op == 5'd4) return 6;
    return 4;
  endfunction

  // Instruction-level reference: fetch microsteps, then per-opcode recipe.
  function automatic outs_t model(input logic [4:0] op, input int t,
                                  input logic ill);
    outs_t o;
    o = '0;
    o.run = 1'b1;
    o.step = 4'(t);
    o.ill = ill | ((t == 3) && is_undef(op));
    if (t == 0) begin
      o.bs[20] = 1; o.en[25] = 1; o.en[18] = 1; o.cs = 5'd14;
    end else if (t == 1) begin
      o.bs[19] = 1; o.en[20] = 1; o.en[21] = 1; o.md = 1; o.rr = 1;
    end else if (t == 2) begin
      o.bs[21] = 1; o.en[24] = 1;
    end else begin
      case (op)
        5'd0, 5'd1, 5'd2: begin
          if (t == 3) begin o.grb = 1; o.ba = 1; o.en[19] = 1; end
          if (t == 4) begin o.bs[23] = 1; o.cs = 5'd1; o.en[18] = 1; end
          if (t == 5 && op == 5'd1) begin
            o.bs[19] = 1; o.gra = 1; o.rin = 1;
          end
          if (t == 5 && op != 5'd1) begin o.bs[19] = 1; o.en[25] = 1; end
          if (t == 6 && op == 5'd0) begin o.md = 1; o.rr = 1; o.en[21] = 1; end
          if (t == 6 && op == 5'd2) begin o.gra = 1; o.rout = 1; o.en[21] = 1; end
          if (t == 7 && op == 5'd0) begin o.bs[21] = 1; o.gra = 1; o.rin = 1; end
          if (t == 7 && op == 5'd2) o.wr = 1;
        end
        5'd3, 5'd4: begin
          if (t == 3) begin o.grb = 1; o.rout = 1; o.en[19] = 1; end
          if (t == 4) begin
            o.grc = 1; o.rout = 1; o.en[18] = 1;
            o.cs = (op == 5'd4) ? 5'd2 : 5'd1;
          end
          if (t == 5) begin o.bs[19] = 1; o.gra = 1; o.rin = 1; end
        end
        default: ;
      endcase
    end
    return o;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    clr = 1'b1;
    bus.start = 1'b0;
    @(negedge clk);
    clr = 1'b0;
  endtask

  // Leaves the bench at the falling edge inside T0.
  task automatic to_t0(input logic [31:0] ir);
    do_reset();
    bus.ir = ir;
    bus.mem_rdy = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic measure_len(input logic [31:0] ir, output int n);
    to_t0(ir);
    n = 1;
    @(negedge clk);
    #1;
    while (bus.step != 4'd0 && n < 30) begin
      n++;
      @(negedge clk);
      #1;
    end
  endtask

  task automatic run_random(input int n_instr);
    logic        ill;
    logic [4:0]  op;
    logic [31:0] word;
    int          r, waits;
    logic        stretch;
    ill = 1'b0;
    do_reset();
    @(negedge clk);
    bus.start = 1'b1;
    bus.ir = $urandom;
    bus.mem_rdy = 1'($urandom);
    #1 check("rnd_idle", sample(), idle_o(1'b0));
    for (int i = 0; i < n_instr; i++) begin
      r = $urandom_range(0, 9);
      if (r == 5) op = 5'b11010;
      else if (r == 6) begin
        op = 5'($urandom_range(5, 31));
        while (!is_undef(op)) op = 5'($urandom_range(5, 31));
      end else op = 5'($urandom_range(0, 4));
      if (i == n_instr - 1 && r > 6) op = 5'b11011;
      word = {op, 27'($urandom)};
      for (int t = 0; t < instr_len(op); t++) begin
        stretch = 1'b0;
        waits = 0;
`ifdef CU_MEM_WAIT_EN
        stretch = (t == 1) || (t == 6 && op == 5'd0) ||
                  (t == 7 && op == 5'd2);
        if (stretch) waits = $urandom_range(0, 2);
`endif
        for (int w = 0; w <= waits; w++) begin
          @(negedge clk);
          bus.start = 1'($urandom);
          bus.ir = (t >= 3) ? word : $urandom;
          bus.mem_rdy = stretch ? (w == waits) : 1'($urandom);
          #1 check($sformatf("rnd_op%0d_t%0d", op, t),
                   sample(), model(op, t, ill));
        end
        if (t == 3 && is_undef(op)) ill = 1'b1;
      end
      if (op == 5'b11011) begin
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          bus.start = 1'($urandom);
          #1 check("rnd_halt", sample(), idle_o(ill));
        end
        break;
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  vecs[12];
    outs_t exp;
    outs_t ref_o;
    int    n, cnt, bad;

    vecs[0]  = '{"fetch_t0", IR_LDI, 0, 32'h0204_0000, 32'h0010_0000, 5'd14, 9'd0};
    vecs[1]  = '{"fetch_t1", IR_LDI, 1, 32'h0030_0000, 32'h0008_0000, 5'd0, C_MD | C_RR};
    vecs[2]  = '{"fetch_t2", IR_LDI, 2, 32'h0100_0000, 32'h0020_0000, 5'd0, 9'd0};
    vecs[3]  = '{"ld_t3", IR_LD, 3, 32'h0008_0000, 32'h0, 5'd0, C_GRB | C_BA};
    vecs[4]  = '{"ld_t4", IR_LD, 4, 32'h0004_0000, 32'h0080_0000, 5'd1, 9'd0};
    vecs[5]  = '{"ld_t6", IR_LD, 6, 32'h0020_0000, 32'h0, 5'd0, C_MD | C_RR};
    vecs[6]  = '{"ld_t7", IR_LD, 7, 32'h0, 32'h0020_0000, 5'd0, C_GRA | C_RIN};
    vecs[7]  = '{"ldi_t5", IR_LDI, 5, 32'h0, 32'h0008_0000, 5'd0, C_GRA | C_RIN};
    vecs[8]  = '{"st_t6", IR_ST, 6, 32'h0020_0000, 32'h0, 5'd0, C_GRA | C_ROUT};
    vecs[9]  = '{"st_t7", IR_ST, 7, 32'h0, 32'h0, 5'd0, C_WR};
    vecs[10] = '{"add_t4", IR_ADD, 4, 32'h0004_0000, 32'h0, 5'd1, C_GRC | C_ROUT};
    vecs[11] = '{"sub_t4", IR_SUB, 4, 32'h0004_0000, 32'h0, 5'd2, C_GRC | C_ROUT};

    clr = 1'b1;
    bus.start = 1'b1;
    bus.mem_rdy = 1'b1;
    bus.ir = IR_LD;
    repeat (2) @(negedge clk);
    #1 check("reset_state", sample(), idle_o(1'b0));
    clr = 1'b0;

    foreach (vecs[i]) begin
      to_t0(vecs[i].ir);
      repeat (vecs[i].t) @(negedge clk);
      #1;
      exp = '0;
      exp.en = vecs[i].en;
      exp.bs = vecs[i].bs;
      exp.cs = vecs[i].cs;
      {exp.md, exp.rr, exp.wr, exp.gra, exp.grb,
       exp.grc, exp.rin, exp.rout, exp.ba} = vecs[i].ctl;
      exp.run = 1'b1;
      exp.step = 4'(vecs[i].t);
      check(vecs[i].name, sample(), exp);
    end

    to_t0(IR_LD);
    repeat (4) @(negedge clk);
    #1 clr = 1'b1;
    #1 check("clr_mid_ld_t4", sample(), idle_o(1'b0));
    @(negedge clk);
    clr = 1'b0;
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    #1 check("idle_hold", sample(), idle_o(1'b0));

    measure_len(IR_LDI, n);
    check_val("ldi_len", n, 6);
    measure_len(IR_LD, n);
    check_val("ld_len", n, 8);
    measure_len(IR_ADD, n);
    check_val("add_len", n, 6);
    measure_len(IR_NOP, n);
    check_val("nop_len", n, 4);

    to_t0(IR_ST);
    cnt = 0;
    for (int k = 0; k < 9; k++) begin
      #1 if (bus.WriteRAM) cnt++;
      @(negedge clk);
    end
    check_val("st_wr_once", cnt, 1);

    to_t0(IR_BAD);
    #1 check_val("illegal_t0", int'(bus.illegal), 0);
    repeat (3) @(negedge clk);
    #1 check_val("illegal_t3", int'(bus.illegal), 1);
    @(negedge clk);
    #1 check_val("illegal_sticky", int'(bus.illegal), 1);
    check_val("illegal_next_t0", int'(bus.step), 0);

    to_t0(IR_HALT);
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      #1 if (sample() !== idle_o(1'b0)) bad++;
      @(negedge clk);
    end
    check_val("halt_hold20", bad, 0);
    bus.start = 1'b0;

`ifdef CU_MEM_WAIT_EN
    to_t0(IR_LDI);
    bus.mem_rdy = 1'b0;
    @(negedge clk);
    #1 ref_o = sample();
    check_val("wait_t1_step", int'(ref_o.step), 1);
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 2) bus.mem_rdy = 1'b1;
      #1 if (sample() !== ref_o) bad++;
    end
    check_val("wait_t1_steady", bad, 0);
    @(negedge clk);
    #1 check_val("wait_then_t2", int'(bus.step), 2);
`else
    to_t0(IR_LDI);
    bus.mem_rdy = 1'b0;
    @(negedge clk);
    #1 ref_o = sample();
    check_val("nowait_t1", int'(ref_o.step), 1);
    @(negedge clk);
    #1 check_val("nowait_t2", int'(bus.step), 2);
`endif

    for (int k = 0; k < 3; k++) run_random(25);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hardwired control unit for the single-bus `datapath`. It generates one control-step (T-state) per clock for fetch and for the `ld`, `ldi`, `st`, `add`, `sub`, `nop` and `halt` instructions. It drives the datapath's `enable`, `busSelect`, `Control_Signals`, register-select and RAM strobes directly, which replaces hand-sequenced stimulus. It sits beside `datapath` and reads the `ir` output.

## Interface
- `INC_PC_OP`, 5'd14: ALU code for PC increment.
- `ADD_OP`, 5'd1: ALU add code.
- `SUB_OP`, 5'd2: ALU subtract code.
- `clk` in 1: system clock, rising edge.
- `clr` in 1: asynchronous, active-high reset.
- `start` in 1: leave IDLE and begin fetching.
- `mem_rdy` in 1: RAM ready; used only with `CU_MEM_WAIT_EN`.
- `ir` in 32: instruction register; opcode is `ir[31:27]`.
- `enable` out 32: register load enables (18 Z, 19 Y, 20 PC, 21 MDR, 24 IR, 25 MAR).
- `busSelect` out 32: one-hot bus source (19 Zlo, 20 PC, 21 MDR, 23 C-sign-extended).
- `Control_Signals` out 5: ALU operation.
- `MD_Read`, `ReadRAM`, `WriteRAM` out 1 each: MDR source select and RAM strobes.
- `Gra`, `Grb`, `Grc`, `Rin`, `Rout`, `BAout` out 1 each: register-file select and control.
- `run` out 1: high while sequencing.
- `illegal` out 1: sticky; set by an undefined opcode.
- `step` out 4: current T index (0–7); 4'hF in IDLE or HALT.

## Operation
- States: IDLE, T0–T7, HALT. Outputs are Moore-decoded from the state register. `busSelect` has at most one bit set.
- IDLE: all outputs 0. On `start`=1, go to T0.
- T0: `busSelect[20]`, `enable[25]`, `enable[18]`, `Control_Signals`=`INC_PC_OP`.
- T1: `busSelect[19]`, `enable[20]`, `enable[21]`, `MD_Read`, `ReadRAM`.
- T2: `busSelect[21]`, `enable[24]`.
- T3 onward decode the opcode from `ir[31:27]`.
- `ld` 5'b00000:
  - T3: `Grb`, `BAout`, `enable[19]`.
  - T4: `busSelect[23]`, `ADD_OP`, `enable[18]`.
  - T5: `busSelect[19]`, `enable[25]`.
  - T6: `MD_Read`, `ReadRAM`, `enable[21]`.
  - T7: `busSelect[21]`, `Gra`, `Rin`. Then go to T0.
- `ldi` 5'b00001: T3 and T4 as `ld`. T5: `busSelect[19]`, `Gra`, `Rin`. Then go to T0.
- `st` 5'b00010:
  - T3–T5 as `ld`.
  - T6: `Gra`, `Rout`, `enable[21]` with `MD_Read`=0.
  - T7: `WriteRAM`. Then go to T0.
- `add` 5'b00011 and `sub` 5'b00100:
  - T3: `Grb`, `Rout`, `enable[19]`.
  - T4: `Grc`, `Rout`, `enable[18]`, with `ADD_OP` or `SUB_OP`.
  - T5: `busSelect[19]`, `Gra`, `Rin`. Then go to T0.
- `nop` 5'b11010: T3 asserts nothing, then go to T0.
- `halt` 5'b11011: T3 goes to HALT. HALT has all outputs 0 and `run`=0, and is left only via `clr`.
- Any other opcode: handled as `nop` and sets `illegal`=1. `illegal` clears only on `clr`.
- `start` is ignored outside IDLE.

## Timing
- Each T-state lasts exactly one clock unless it is stretched by a memory wait.
- Instruction lengths:
  - `ld` and `st`: 8 cycles.
  - `ldi`, `add`, `sub`: 6 cycles.
  - `nop` and illegal opcodes: 4 cycles.
- The first T0 occurs on the edge after `start` is sampled high in IDLE.
- `ir` is valid from T3 onward, because IR loads at the end of T2.
- Reset values: every output is 0 while `clr`=1, including `run`, `illegal`, `enable`, `busSelect` and `Control_Signals`; `step`=4'hF. The state returns to IDLE immediately.
- `clr` asserted mid-instruction aborts the instruction with no further strobes. Partially updated datapath registers are not restored.

## Configuration
- `CU_MEM_WAIT_EN` defined:
  - The fetch T1, `ld` T6 and `st` T7 states hold, with all their outputs steady, until `mem_rdy`=1 is sampled. The state advances on that edge.
  - If `mem_rdy`=1 on the first cycle, there is no stretch.
- `CU_MEM_WAIT_EN` undefined: `mem_rdy` is ignored and every state lasts one cycle.

## Test plan
- Reset and idle: assert `clr` mid-T4 of `ld` → the same cycle shows all outputs 0 and `step`=4'hF. After release, holding `start`=0 keeps the block in IDLE.
- `ldi`, `ir`=32'h0880_0005: the sequence T0..T5 runs, then T0 again. T5 shows `busSelect[19]`, `Gra`, `Rin`. Total 6 cycles.
- `ld`, `ir`=32'h0080_0000: T6 shows `ReadRAM`=`MD_Read`=1 and `enable[21]`=1. T7 shows `busSelect[21]`, `Gra`, `Rin`. Total 8 cycles.
- `st`, opcode 5'b00010: T6 has `MD_Read`=0 and `Rout`=1. T7 has `WriteRAM`=1 for exactly one cycle.
- Opcode 5'b11111 → `illegal` rises at T3 and stays high after the next fetch. Opcode `halt` → `run`=0, `step`=4'hF, and the block stays halted for 20 cycles.
- With `CU_MEM_WAIT_EN`: hold `mem_rdy`=0 for 3 cycles in T1 → T1 lasts 4 cycles with outputs unchanged, then T2 follows.
